maxpool_relu1: RTL and testbench

MAXPOOL_RELU1 -- requirements
Module: maxpool_relu1

---
 rtl/maxpool_relu1.sv | 135 +++++++++++++
 tb/tb_maxpool_relu1.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/maxpool_relu1.sv
// 2x2 stride-2 max pooling over three conv1 channels, one line buffer per channel.
// Optional build macro RELU_EN rectifies each pooled result before it is registered.

module maxpool_relu1_lane #(
   parameter int WIDTH     = 24,
   parameter int DATA_BITS = 12,
   parameter int IW        = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic                 col_odd,
   input  logic                 row_odd,
   input  logic [IW-1:0]        idx,
   input  logic [DATA_BITS-1:0] sample,
   output logic [DATA_BITS-1:0] data_out
);
   logic signed [DATA_BITS-1:0] left_q, left_d, dout_q, dout_d;
   logic signed [DATA_BITS-1:0] smp, pair, above, result;
   logic signed [DATA_BITS-1:0] lbuf_mem [WIDTH/2];

   assign smp = $signed(sample);

   always_comb begin
      above  = lbuf_mem[idx];
      pair   = (smp > left_q) ? smp : left_q;
      result = (above > pair) ? above : pair;
`ifdef RELU_EN
      if (result[DATA_BITS-1]) result = '0;
`endif
      left_d = left_q;
      dout_d = dout_q;
      if (valid_in && !col_odd) left_d = smp;
      if (valid_in && col_odd && row_odd) dout_d = result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         left_q <= '0;
         dout_q <= '0;
      end else begin
         left_q <= left_d;
         dout_q <= dout_d;
      end
   end

   // Row-0 of every frame rewrites each entry before row-1 reads it, so no reset is needed.
   always_ff @(posedge clk) begin
      if (valid_in && col_odd && !row_odd) lbuf_mem[idx] <= pair;
   end

   assign data_out = dout_q;
endmodule

module maxpool_relu1 #(
   parameter int WIDTH     = 24,
   parameter int HEIGHT    = 24,
   parameter int DATA_BITS = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic [DATA_BITS-1:0] data_in_1,
   input  logic [DATA_BITS-1:0] data_in_2,
   input  logic [DATA_BITS-1:0] data_in_3,
   output logic [DATA_BITS-1:0] data_out_1,
   output logic [DATA_BITS-1:0] data_out_2,
   output logic [DATA_BITS-1:0] data_out_3,
   output logic                 valid_out,
   output logic                 frame_done
);
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH/2) : 1;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          valid_out_q, valid_out_d, frame_done_q, frame_done_d;
   logic          col_last, row_last;
   logic [IW-1:0] idx;
   logic [2:0][DATA_BITS-1:0] din, dout;

   assign col_last = (col_q == CW'(WIDTH-1));
   assign row_last = (row_q == RW'(HEIGHT-1));
   assign idx      = IW'(col_q >> 1);
   assign din      = {data_in_3, data_in_2, data_in_1};

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      valid_out_d  = valid_in && col_q[0] && row_q[0];
      frame_done_d = valid_in && col_last && row_last;
      if (valid_in) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_lane
      maxpool_relu1_lane #(.WIDTH(WIDTH), .DATA_BITS(DATA_BITS), .IW(IW)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .valid_in (valid_in),
         .col_odd  (col_q[0]),
         .row_odd  (row_q[0]),
         .idx      (idx),
         .sample   (din[g]),
         .data_out (dout[g])
      );
   end

   assign data_out_1 = dout[0];
   assign data_out_2 = dout[1];
   assign data_out_3 = dout[2];
   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_maxpool_relu1.sv
// Randomized bench for maxpool_relu1: frame-image model pools each 2x2 window directly.
module tb_maxpool_relu1;
   localparam int W = 24, H = 24;

   logic        clk = 1'b0, rst = 1'b1, valid_in = 1'b0;
   logic [11:0] data_in_1 = '0, data_in_2 = '0, data_in_3 = '0;
   logic [11:0] data_out_1, data_out_2, data_out_3;
   logic        valid_out, frame_done;

   maxpool_relu1 dut (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
      .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
      .valid_out(valid_out), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int mr = 0, mc = 0, fd_cnt = 0;
   logic signed [11:0] img [3][H][W];
   logic [11:0] last_out [3];
   logic [11:0] out_log [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic signed [11:0] smax(input logic signed [11:0] a, input logic signed [11:0] b);
      return (a > b) ? a : b;
   endfunction

   // One clock: drive inputs, let the edge happen, update the model, check outputs 1 time unit later.
   task automatic step(input logic v, input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
      logic exp_v, exp_fd;
      logic signed [11:0] m;
      valid_in = v; data_in_1 = a; data_in_2 = b; data_in_3 = c;
      @(posedge clk);
      exp_v = 1'b0; exp_fd = 1'b0;
      if (v) begin
         img[0][mr][mc] = a; img[1][mr][mc] = b; img[2][mr][mc] = c;
         if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            exp_v  = 1'b1;
            exp_fd = (mr == H-1) && (mc == W-1);
            for (int ch = 0; ch < 3; ch++) begin
               m = smax(smax(img[ch][mr-1][mc-1], img[ch][mr-1][mc]),
                        smax(img[ch][mr][mc-1],   img[ch][mr][mc]));
`ifdef RELU_EN
               if (m < 0) m = 0;
`endif
               last_out[ch] = m;
            end
         end
         mc++;
         if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
      end
      #1;
      chk("valid_out", valid_out, exp_v);
      chk("frame_done", frame_done, exp_fd);
      chk("data_out_1", data_out_1, last_out[0]);
      chk("data_out_2", data_out_2, last_out[1]);
      chk("data_out_3", data_out_3, last_out[2]);
      if (valid_out) out_log.push_back(data_out_1);
      if (frame_done) fd_cnt++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; valid_in = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
         chk("rst_valid_out", valid_out, 0);
         chk("rst_frame_done", frame_done, 0);
         chk("rst_data", {data_out_3, data_out_2, data_out_1}, 0);
      end
      rst = 1'b0;
      mr = 0; mc = 0;
      for (int ch = 0; ch < 3; ch++) last_out[ch] = '0;
   endtask

   // mode 0 ramp, 1 single-100 rotating max, 2 random; gmode 0 none, 1 pattern 1,0,0, 2 random gaps
   task automatic run_frame(input int mode, input int gmode, input int stop_r, input int stop_c);
      logic [11:0] a, b, c;
      int w, q;
      for (int r = 0; r < H; r++) begin
         for (int cc = 0; cc < W; cc++) begin
            if (r == stop_r && cc == stop_c) return;
            case (mode)
               0: begin a = 12'(r*W + cc); b = 12'hFFB; c = 12'($urandom); end
               1: begin
                  w = (r/2)*(W/2) + cc/2;
                  q = (r%2)*2 + (cc%2);
                  a = (q == w%4) ? 12'd100 : 12'd0; b = a; c = a;
               end
               default: begin a = 12'($urandom); b = 12'($urandom); c = 12'($urandom); end
            endcase
            step(1'b1, a, b, c);
            if (gmode == 1) begin
               step(1'b0, 12'($urandom), 12'($urandom), 12'($urandom));
               step(1'b0, 12'($urandom), 12'($urandom), 12'($urandom));
            end else if (gmode == 2 && $urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) step(1'b0, 12'($urandom), 12'($urandom), 12'($urandom));
            end
         end
      end
   endtask

   task automatic check_ramp_log(input string tag);
      chk({tag, "_count"}, out_log.size(), 144);
      chk({tag, "_fd"}, fd_cnt, 1);
      if (out_log.size() == 144) begin
         chk({tag, "_first"}, out_log[0], 25);
         chk({tag, "_second"}, out_log[1], 27);
         chk({tag, "_last"}, out_log[143], 575);
      end
`ifdef RELU_EN
      chk({tag, "_ch2neg"}, data_out_2, 12'h000);
`else
      chk({tag, "_ch2neg"}, data_out_2, 12'hFFB);
`endif
   endtask

   initial begin
      do_reset(3);
      repeat (2) step(1'b0, 12'h7FF, 12'h7FF, 12'h7FF);

      out_log.delete(); fd_cnt = 0;
      run_frame(0, 0, -1, -1);
      check_ramp_log("ramp");

      out_log.delete(); fd_cnt = 0;
      run_frame(1, 0, -1, -1);
      chk("maxpos_count", out_log.size(), 144);
      foreach (out_log[i]) if (out_log[i] != 12'd100) chk("maxpos_val", out_log[i], 100);

      out_log.delete(); fd_cnt = 0;
      run_frame(0, 1, -1, -1);
      check_ramp_log("gap_ramp");

      out_log.delete(); fd_cnt = 0;
      run_frame(2, 2, -1, -1);
      chk("rand_count", out_log.size(), 144);

      run_frame(0, 0, 7, 13);
      do_reset(2);
      repeat (3) step(1'b0, 12'($urandom), 12'($urandom), 12'($urandom));
      out_log.delete(); fd_cnt = 0;
      run_frame(0, 0, -1, -1);
      check_ramp_log("post_rst_ramp");

      out_log.delete(); fd_cnt = 0;
      run_frame(2, 0, -1, -1);
      run_frame(2, 0, -1, -1);
      chk("b2b_count", out_log.size(), 288);
      chk("b2b_fd", fd_cnt, 2);

      repeat (3) step(1'b0, 12'($urandom), 12'($urandom), 12'($urandom));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
